// File: rtl/coin_lane_scheduler.sv
// coin_lane_scheduler: sequences the coin generator. Chooses when a coin
// appears, which lane it uses, when it retires (collected or missed), and
// keeps saturating collected/missed statistics.
// Optional build macro COIN_STREAK_EN adds o_streak / o_bonus outputs.
module coin_lane_scheduler #(
  parameter int          TRAVEL_FRAMES = 120,
  parameter int          CLEAR_FRAMES  = 2,
  parameter int          GAP_MIN       = 30,
  parameter int          GAP_MASK      = 63,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_game_run,
  input  logic [1:0] i_barrier_lane,
  input  logic       i_penguin_hit,
  input  logic       i_in_position,
  output logic [1:0] o_active,
  output logic       o_busy,
  output logic [7:0] o_coin_count,
  output logic [7:0] o_miss_count
`ifdef COIN_STREAK_EN
  ,
  output logic [3:0] o_streak,
  output logic       o_bonus
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    RUN   = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [8:0] TRAVEL_LOAD = 9'(TRAVEL_FRAMES - 1);
  localparam logic [8:0] CLEAR_LOAD  = 9'(CLEAR_FRAMES - 1);
  localparam logic [8:0] GAP_BASE    = 9'(GAP_MIN);
  localparam logic [7:0] GAP_MSK     = 8'(GAP_MASK);

  state_t      state;
  logic [8:0]  cnt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  // The coin generator's in-zone flag is informational only.
  logic unused_in_position;
  assign unused_in_position = i_in_position;

  // Galois step for x^16+x^14+x^13+x^11, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Idle length before the next coin: fixed minimum plus a masked random part.
  function automatic logic [8:0] gap_load(input logic [15:0] v);
    gap_load = GAP_BASE + {1'b0, v[7:0] & GAP_MSK};
  endfunction

  // Random lane, never "none", stepped aside when it collides with the barrier.
  function automatic logic [1:0] pick_lane(input logic [15:0] v,
                                           input logic [1:0]  barrier);
    logic [1:0] l;
    l = (v[1:0] == 2'b00) ? 2'b10 : v[1:0];
    if ((barrier != 2'b00) && (l == barrier))
      l = (l == 2'b11) ? 2'b01 : l + 2'b01;
    pick_lane = l;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef COIN_STREAK_EN
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic is_bonus(input logic [3:0] v);
    is_bonus = (v == 4'd5) || (v == 4'd10) || (v == 4'd15);
  endfunction
`endif

  // Lane picks and gap reloads see the LFSR value this frame tick produces.
  always_comb begin
    lfsr_nxt = i_frame_tick ? lfsr_step(lfsr) : lfsr;
  end

  // Scheduler FSM with registered lane select, busy flag and statistics.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= 9'd0;
      lfsr         <= LFSR_SEED;
      o_active     <= 2'b00;
      o_busy       <= 1'b0;
      o_coin_count <= 8'd0;
      o_miss_count <= 8'd0;
`ifdef COIN_STREAK_EN
      o_streak     <= 4'd0;
      o_bonus      <= 1'b0;
`endif
    end else if (!i_game_run) begin
      // Freeze: abandon any coin without counting it; LFSR and stats hold.
      state    <= IDLE;
      o_active <= 2'b00;
      o_busy   <= 1'b0;
`ifdef COIN_STREAK_EN
      o_bonus  <= 1'b0;
`endif
    end else begin
`ifdef COIN_STREAK_EN
      o_bonus <= 1'b0;
`endif
      lfsr <= lfsr_nxt;
      case (state)
        IDLE: begin
          cnt      <= gap_load(lfsr_nxt);
          state    <= GAP;
          o_active <= 2'b00;
          o_busy   <= 1'b0;
        end
        GAP: begin
          if (i_frame_tick) begin
            if (cnt == 9'd0) begin
              cnt      <= TRAVEL_LOAD;
              state    <= RUN;
              o_active <= pick_lane(lfsr_nxt, i_barrier_lane);
              o_busy   <= 1'b1;
            end else begin
              cnt <= cnt - 9'd1;
            end
          end
        end
        RUN: begin
          if (i_frame_tick) begin
            if (i_penguin_hit) begin
              // A hit on the timeout frame still counts as a collect.
              o_coin_count <= sat_inc8(o_coin_count);
              cnt          <= CLEAR_LOAD;
              state        <= CLEAR;
              o_active     <= 2'b00;
`ifdef COIN_STREAK_EN
              o_streak     <= sat_inc4(o_streak);
              o_bonus      <= (o_streak != 4'hF) && is_bonus(sat_inc4(o_streak));
`endif
            end else if (cnt == 9'd0) begin
              // Missed coin also gets the full clear window.
              o_miss_count <= sat_inc8(o_miss_count);
              cnt          <= CLEAR_LOAD;
              state        <= CLEAR;
              o_active     <= 2'b00;
`ifdef COIN_STREAK_EN
              o_streak     <= 4'd0;
`endif
            end else begin
              cnt <= cnt - 9'd1;
            end
          end
        end
        CLEAR: begin
          if (i_frame_tick) begin
            if (cnt == 9'd0) begin
              cnt    <= gap_load(lfsr_nxt);
              state  <= GAP;
              o_busy <= 1'b0;
            end else begin
              cnt <= cnt - 9'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          o_active <= 2'b00;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_lane_scheduler.sv
// Testbench for coin_lane_scheduler: randomized frames checked against a
// behavioural model of the scheduler's rules.
module tb_coin_lane_scheduler;

  localparam int          TRAVEL = 12;
  localparam int          CLEARF = 2;
  localparam int          GMIN   = 3;
  localparam int          GMASK  = 3;
  localparam logic [15:0] SEED   = 16'hACE1;
`ifdef COIN_STREAK_EN
  localparam int VW = 24;
`else
  localparam int VW = 19;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst_n, i_frame_tick, i_game_run, i_penguin_hit, i_in_position;
  logic [1:0] i_barrier_lane;
  logic [1:0] o_active;
  logic       o_busy;
  logic [7:0] o_coin_count, o_miss_count;
`ifdef COIN_STREAK_EN
  logic [3:0] o_streak;
  logic       o_bonus;
`endif

  coin_lane_scheduler #(
    .TRAVEL_FRAMES(TRAVEL), .CLEAR_FRAMES(CLEARF), .GAP_MIN(GMIN),
    .GAP_MASK(GMASK), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_frame_tick(i_frame_tick),
    .i_game_run(i_game_run), .i_barrier_lane(i_barrier_lane),
    .i_penguin_hit(i_penguin_hit), .i_in_position(i_in_position),
    .o_active(o_active), .o_busy(o_busy),
    .o_coin_count(o_coin_count), .o_miss_count(o_miss_count)
`ifdef COIN_STREAK_EN
    , .o_streak(o_streak), .o_bonus(o_bonus)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_GAP, M_RUN, M_CLEAR} phase_t;
  phase_t      m_state;
  int          m_cnt;
  logic [15:0] m_lfsr;
  logic [1:0]  m_active;
  logic        m_busy;
  logic [7:0]  m_coins, m_miss;
  logic [3:0]  m_streak;
  logic        m_bonus;
  logic [1:0]  rot [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

  function automatic logic [15:0] adv(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [1:0] lane_of(input logic [15:0] v, input logic [1:0] b);
    logic [1:0] l;
    l = (v[1:0] == 2'd0) ? 2'd2 : v[1:0];
    if (b != 2'd0 && l == b) l = rot[l];
    return l;
  endfunction

  task model_edge();
    if (!i_rst_n) begin
      m_state = M_IDLE; m_cnt = 0; m_lfsr = SEED; m_active = 0;
      m_coins = 0; m_miss = 0; m_streak = 0; m_bonus = 0;
    end else if (!i_game_run) begin
      m_state = M_IDLE; m_active = 0; m_bonus = 0;
    end else begin
      m_bonus = 0;
      if (i_frame_tick) m_lfsr = adv(m_lfsr);
      case (m_state)
        M_IDLE: begin m_cnt = GMIN + (int'(m_lfsr[7:0]) & GMASK); m_state = M_GAP; end
        M_GAP: if (i_frame_tick) begin
          if (m_cnt == 0) begin
            m_active = lane_of(m_lfsr, i_barrier_lane); m_cnt = TRAVEL - 1; m_state = M_RUN;
          end else m_cnt--;
        end
        M_RUN: if (i_frame_tick) begin
          if (i_penguin_hit) begin
            if (m_coins != 8'd255) m_coins++;
            if (m_streak != 4'd15) begin m_streak++; m_bonus = (m_streak % 5 == 0); end
            m_active = 0; m_cnt = CLEARF - 1; m_state = M_CLEAR;
          end else if (m_cnt == 0) begin
            if (m_miss != 8'd255) m_miss++;
            m_streak = 0; m_active = 0; m_cnt = CLEARF - 1; m_state = M_CLEAR;
          end else m_cnt--;
        end
        M_CLEAR: if (i_frame_tick) begin
          if (m_cnt == 0) begin m_cnt = GMIN + (int'(m_lfsr[7:0]) & GMASK); m_state = M_GAP; end
          else m_cnt--;
        end
      endcase
    end
    m_busy = (m_state == M_RUN) || (m_state == M_CLEAR);
  endtask

  function automatic logic [VW-1:0] dut_vec();
`ifdef COIN_STREAK_EN
    return {o_active, o_busy, o_coin_count, o_miss_count, o_streak, o_bonus};
`else
    return {o_active, o_busy, o_coin_count, o_miss_count};
`endif
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
`ifdef COIN_STREAK_EN
    return {m_active, m_busy, m_coins, m_miss, m_streak, m_bonus};
`else
    return {m_active, m_busy, m_coins, m_miss};
`endif
  endfunction

  // ---------------- stimulus primitives ----------------
  task step(input bit tk);
    i_frame_tick  = tk;
    i_in_position = 1'($urandom);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // A frame: a few quiet clocks, then the tick; outputs examined right after it.
  task frame();
    repeat ($urandom_range(0, 2)) step(1'b0);
    step(1'b1);
  endtask

  // ---------------- scenarios ----------------
  task test_reset();
    i_rst_n = 0; i_game_run = 0; i_penguin_hit = 0; i_barrier_lane = 0;
    repeat (3) begin
      step(1'($urandom));
      vectors++;
      if ({o_active, o_busy, o_coin_count, o_miss_count} !== 19'd0) begin
        miscompares++;
        $display("FAIL reset: got %h required 0", {o_active, o_busy, o_coin_count, o_miss_count});
      end
    end
  endtask

  task test_first_coin();
    int ticks;
    int exp_ticks;
    exp_ticks = GMIN + (int'(SEED[7:0]) & GMASK) + 1;
    i_rst_n = 1; i_game_run = 1;
    step(1'b0);
    ticks = 0;
    while (o_active == 2'd0 && ticks < 100) begin
      frame(); ticks++;
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL first_coin: dut=%h model=%h", dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (ticks !== exp_ticks || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL first_coin_latency: ticks=%0d busy=%b required ticks=%0d busy=1", ticks, o_busy, exp_ticks);
    end
  endtask

  task test_collect();
    logic [7:0] c0, mi0;
    int clr;
    c0 = o_coin_count; mi0 = o_miss_count;
    i_penguin_hit = 0;
    repeat (9) begin
      frame();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL collect_run: dut=%h model=%h", dut_vec(), mdl_vec());
      end
    end
    i_penguin_hit = 1;
    frame();
    vectors++;
    if (o_coin_count !== c0 + 8'd1 || o_miss_count !== mi0 || o_active !== 2'd0 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL collect_hit: coins=%0d miss=%0d lane=%0d busy=%b required %0d/%0d/0/1",
               o_coin_count, o_miss_count, o_active, o_busy, c0 + 8'd1, mi0);
    end
    clr = 0;
    while (o_busy && clr < 20) begin frame(); clr++; end
    vectors++;
    if (clr !== CLEARF || o_coin_count !== c0 + 8'd1 || dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL collect_clear: clear_ticks=%0d coins=%0d required %0d/%0d", clr, o_coin_count, CLEARF, c0 + 8'd1);
    end
    i_penguin_hit = 0;
  endtask

  task test_miss();
    logic [7:0] c0, mi0;
    int n;
    n = 0;
    while (m_state != M_RUN && n < 50) begin frame(); n++; end
    c0 = o_coin_count; mi0 = o_miss_count;
    n = 0;
    while (o_miss_count == mi0 && n < 50) begin
      frame(); n++;
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL miss_run: dut=%h model=%h", dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (n !== TRAVEL || o_miss_count !== mi0 + 8'd1 || o_coin_count !== c0 || o_active !== 2'd0) begin
      miscompares++;
      $display("FAIL miss_timeout: ticks=%0d miss=%0d coins=%0d lane=%0d required %0d/%0d/%0d/0",
               n, o_miss_count, o_coin_count, o_active, TRAVEL, mi0 + 8'd1, c0);
    end
  endtask

  task test_lane_rotate();
    logic [15:0] nl;
    logic [1:0]  raw, want;
    int n;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!(m_state == M_GAP && m_cnt == 0) && n < 50) begin frame(); n++; end
      nl  = adv(m_lfsr);
      raw = (nl[1:0] == 2'd0) ? 2'd2 : nl[1:0];
      if (k % 2 == 0) begin
        i_barrier_lane = raw;
        want = (raw == 2'd3) ? 2'd1 : raw + 2'd1;
      end else begin
        i_barrier_lane = (raw == 2'd1) ? 2'd3 : 2'd1;
        want = raw;
      end
      frame();
      vectors++;
      if (o_active !== want || dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL lane_pick: lane=%0d barrier=%0d required %0d", o_active, i_barrier_lane, want);
      end
      i_penguin_hit = 1; frame(); i_penguin_hit = 0; i_barrier_lane = 0;
    end
  endtask

  task test_run_drop();
    logic [7:0] c0, mi0;
    int n;
    n = 0;
    while (m_state != M_RUN && n < 50) begin frame(); n++; end
    frame();
    c0 = o_coin_count; mi0 = o_miss_count;
    i_game_run = 0;
    repeat (4) begin
      step(1'($urandom));
      vectors++;
      if (o_active !== 2'd0 || o_busy !== 1'b0 || o_coin_count !== c0 || o_miss_count !== mi0) begin
        miscompares++;
        $display("FAIL run_drop: lane=%0d busy=%b coins=%0d miss=%0d required 0/0/%0d/%0d",
                 o_active, o_busy, o_coin_count, o_miss_count, c0, mi0);
      end
    end
    i_game_run = 1;
    step(1'b0);
    n = 0;
    while (m_state != M_RUN && n < 50) begin
      frame(); n++;
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL run_resume: dut=%h model=%h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task test_reset_mid_clear();
    i_penguin_hit = 1; frame(); i_penguin_hit = 0;
    vectors++;
    if (o_busy !== 1'b1 || o_active !== 2'd0) begin
      miscompares++;
      $display("FAIL enter_clear: busy=%b lane=%0d required 1/0", o_busy, o_active);
    end
    i_rst_n = 0; step(1'b0);
    vectors++;
    if (dut_vec() !== {VW{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got %h required 0", dut_vec());
    end
    i_rst_n = 1; step(1'b0);
  endtask

  task test_saturation();
    int n;
    int bonus_seen;
    i_penguin_hit = 1; n = 0; bonus_seen = 0;
    while ((o_coin_count != 8'd255 || m_coins != 8'd255 || n < 2600) && n < 4000) begin
      i_barrier_lane = 2'($urandom);
      step(1'b1); n++;
`ifdef COIN_STREAK_EN
      if (o_bonus) bonus_seen++;
`endif
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL saturation: dut=%h model=%h", dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (o_coin_count !== 8'd255) begin
      miscompares++;
      $display("FAIL coin_saturate: coins=%0d required 255", o_coin_count);
    end
`ifdef COIN_STREAK_EN
    vectors++;
    if (bonus_seen !== 3 || o_streak !== 4'd15) begin
      miscompares++;
      $display("FAIL bonus_pulses: pulses=%0d streak=%0d required 3/15", bonus_seen, o_streak);
    end
`endif
    i_penguin_hit = 0; i_barrier_lane = 0;
    n = 0;
    while (m_miss == o_miss_count && o_miss_count == 8'd0 && n < 200) begin step(1'b1); n++; end
    repeat (2) step(1'b0);
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL miss_after_streak: dut=%h model=%h", dut_vec(), mdl_vec());
    end
`ifdef COIN_STREAK_EN
    vectors++;
    if (o_streak !== 4'd0) begin
      miscompares++;
      $display("FAIL streak_clear: streak=%0d required 0", o_streak);
    end
`endif
  endtask

  task test_random();
    for (int i = 0; i < 3000; i++) begin
      i_game_run     = ($urandom_range(0, 99) >= 3);
      i_penguin_hit  = ($urandom_range(0, 99) < 25);
      i_barrier_lane = 2'($urandom);
      step($urandom_range(0, 99) < 45);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    i_rst_n = 0; i_frame_tick = 0; i_game_run = 0; i_penguin_hit = 0;
    i_in_position = 0; i_barrier_lane = 0;
    test_reset();
    test_first_coin();
    test_collect();
    test_miss();
    test_lane_rotate();
    test_run_drop();
    test_reset_mid_clear();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
